// File: rtl/logicnet_lut_pkg.sv
// Shared types and helpers for the LogicNets LUT layer: FSM state encoding and table depth.
package logicnet_lut_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int tbl_depth(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/logicnet_lut_neuron.sv
// One LUT neuron: a register-based truth table with write port and combinational lookup.
// With LOGICNET_LUT_READBACK_EN defined, a second combinational read port serves config readback.
module logicnet_lut_neuron
  import logicnet_lut_pkg::*;
#(
  parameter int LUT_IN_BITS = 6,
  parameter int OUT_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [LUT_IN_BITS-1:0] wr_addr,
  input  logic [OUT_BITS-1:0]    wr_data,
  input  logic [LUT_IN_BITS-1:0] lookup_addr,
  output logic [OUT_BITS-1:0]    lookup_data
`ifdef LOGICNET_LUT_READBACK_EN
  ,
  input  logic [LUT_IN_BITS-1:0] rd_addr,
  output logic [OUT_BITS-1:0]    rd_data
`endif
);

  localparam int DEPTH = tbl_depth(LUT_IN_BITS);

  // Flop-based so reset can clear every entry; the lookup must be combinational anyway.
  logic [OUT_BITS-1:0] table_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_reg[i] <= '0;
      end
    end else if (wr_en) begin
      table_reg[wr_addr] <= wr_data;
    end
  end

  assign lookup_data = table_reg[lookup_addr];

`ifdef LOGICNET_LUT_READBACK_EN
  assign rd_data = table_reg[rd_addr];
`endif

endmodule

// File: rtl/logicnet_lut_layer.sv
// Pipelined layer of LUT neurons with valid/ready streaming and a LOAD/RUN/DRAIN config FSM.
// Optional feature macro: LOGICNET_LUT_READBACK_EN adds cfg_re/cfg_rdata table readback.
module logicnet_lut_layer
  import logicnet_lut_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int LUT_IN_BITS = 6,
  parameter int OUT_BITS    = 2,
  localparam int NW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_NEURONS*LUT_IN_BITS-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0]    out_data,
  input  logic                               cfg_start,
  input  logic                               cfg_done,
  input  logic                               cfg_we,
  input  logic [NW-1:0]                      cfg_neuron,
  input  logic [LUT_IN_BITS-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]                cfg_wdata,
  output logic                               cfg_busy,
  output logic                               cfg_err
`ifdef LOGICNET_LUT_READBACK_EN
  ,
  input  logic                               cfg_re,
  output logic [OUT_BITS-1:0]                cfg_rdata
`endif
);

  state_e state_reg, state_next;
  logic                            out_valid_reg;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_reg;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup_all;
  logic                            cfg_err_reg;
  logic                            neuron_legal;
  logic                            illegal_access;
  logic                            xfer;
`ifdef LOGICNET_LUT_READBACK_EN
  logic [OUT_BITS-1:0]             rb_data [NUM_NEURONS];
  logic [OUT_BITS-1:0]             cfg_rdata_reg;
`endif

  // When NUM_NEURONS fills the index range every encoding is legal.
  generate
    if (NUM_NEURONS == (1 << NW)) begin : gen_legal_full
      assign neuron_legal = 1'b1;
    end else begin : gen_legal_cmp
      assign neuron_legal = (int'(cfg_neuron) < NUM_NEURONS);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : gen_neuron
      logicnet_lut_neuron #(
        .LUT_IN_BITS(LUT_IN_BITS),
        .OUT_BITS   (OUT_BITS)
      ) u_neuron (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cfg_we && (state_reg == ST_LOAD) && (cfg_neuron == NW'(gi))),
        .wr_addr    (cfg_addr),
        .wr_data    (cfg_wdata),
        .lookup_addr(in_data[gi*LUT_IN_BITS +: LUT_IN_BITS]),
        .lookup_data(lookup_all[gi*OUT_BITS +: OUT_BITS])
`ifdef LOGICNET_LUT_READBACK_EN
        ,
        .rd_addr    (cfg_addr),
        .rd_data    (rb_data[gi])
`endif
      );
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_LOAD;
    else        state_reg <= state_next;
  end

  // FSM: next state; cfg_start is not looked at in LOAD, so cfg_done wins there
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD:  if (cfg_done)       state_next = ST_RUN;
      ST_RUN:   if (cfg_start)      state_next = ST_DRAIN;
      ST_DRAIN: if (!out_valid_reg) state_next = ST_LOAD;
      default:                      state_next = ST_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_busy = (state_reg != ST_RUN);
    in_ready = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
  end

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= lookup_all;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_comb begin
    illegal_access = cfg_we && ((state_reg != ST_LOAD) || !neuron_legal);
`ifdef LOGICNET_LUT_READBACK_EN
    illegal_access = illegal_access || (cfg_re && !neuron_legal);
`endif
  end

  // A fresh error in the same cycle as cfg_done is kept rather than lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cfg_err_reg <= 1'b0;
    else if (illegal_access)                     cfg_err_reg <= 1'b1;
    else if ((state_reg == ST_LOAD) && cfg_done) cfg_err_reg <= 1'b0;
  end

  assign cfg_err = cfg_err_reg;

`ifdef LOGICNET_LUT_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cfg_rdata_reg <= '0;
    else if (cfg_re) cfg_rdata_reg <= neuron_legal ? rb_data[cfg_neuron] : '0;
  end

  assign cfg_rdata = cfg_rdata_reg;
`endif

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Scoreboard bench for logicnet_lut_layer: stimulus pushes expected outputs, a monitor pops on each beat.
module tb_logicnet_lut_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_start;
  logic        cfg_done;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_wdata;
  logic        cfg_busy;
  logic        cfg_err;
`ifdef LOGICNET_LUT_READBACK_EN
  logic        cfg_re;
  logic [1:0]  cfg_rdata;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_q[$];
  logic [1:0] mdl [4][64];

  always #5 clk = ~clk;

  logicnet_lut_layer #(
    .NUM_NEURONS(4),
    .LUT_IN_BITS(6),
    .OUT_BITS   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_start (cfg_start),
    .cfg_done  (cfg_done),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
`ifdef LOGICNET_LUT_READBACK_EN
    ,
    .cfg_re    (cfg_re),
    .cfg_rdata (cfg_rdata)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [7:0] expect_out(input logic [23:0] d);
    logic [7:0] r;
    for (int n = 0; n < 4; n++) r[n*2 +: 2] = mdl[n][d[n*6 +: 6]];
    return r;
  endfunction

  // Monitor: a beat is taken on the coming rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(out_data), 32'hdead);
      end else begin
        check("beat", 32'(out_data), 32'(sb_q.pop_front()));
      end
    end
  end

  // All tasks start and end at posedge + 1.
  task automatic send(input logic [23:0] d, input logic [7:0] e, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else           sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_entry(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    do_write(n, a, d);
    mdl[n][a] = d;
  endtask

  task automatic pulse_done();
    cfg_done = 1'b1; @(posedge clk); #1; cfg_done = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; @(posedge clk); #1; cfg_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int tw;
    logic [23:0] d;
    logic [23:0] d2;

    for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) mdl[n][a] = 2'b00;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_start = 1'b0; cfg_done = 1'b0; cfg_we = 1'b0;
    cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0;
`ifdef LOGICNET_LUT_READBACK_EN
    cfg_re = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // cfg_done with empty tables, one zero sample, latency 1
    pulse_done();
    @(negedge clk);
    check("run_cfg_busy", 32'(cfg_busy), 32'd0);
    check("run_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(24'h0, 8'h00, w);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Back to LOAD and program tables (neuron0 entry written twice: last wins)
    pulse_start();
    idle(3);
    load_entry(2'd0, 6'b100100, 2'b10);
    load_entry(2'd0, 6'b100100, 2'b01);
    load_entry(2'd3, 6'b001000, 2'b11);
    for (int a = 0; a < 64; a++) begin
      logic [5:0] av;
      av = 6'(a);
      load_entry(2'd1, av, av[1:0] ^ av[5:4]);
    end
    for (int a = 0; a < 16; a++) begin
      logic [5:0] av;
      av = 6'(a);
      load_entry(2'd2, av, av[3:2]);
    end
    @(negedge clk);
    check("load_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    pulse_done();
    send({6'b001000, 12'b0, 6'b100100}, 8'b11_00_00_01, w);

    // 16 back-to-back samples
    tw = 0;
    for (int i = 0; i < 16; i++) begin
      d = {6'(i * 9), 6'(i * 5 + 2), 6'(i + 1), 6'(i * 3)};
      if (i == 5) d[5:0] = 6'b100100;
      if (i == 9) d[23:18] = 6'b001000;
      send(d, expect_out(d), w);
      tw += w;
    end
    check("stream_in_ready_waits", 32'(tw), 32'd0);

    // Output stall for 5 cycles, then 1 beat/cycle
    idle(2);
    out_ready = 1'b0;
    d = {6'b001000, 6'd7, 6'd13, 6'b100100};
    send(d, expect_out(d), w);
    in_valid = 1'b1;
    d2 = {6'd1, 6'd2, 6'd3, 6'd4};
    in_data = d2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'(expect_out(d)));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    tw = 0;
    send(d2, expect_out(d2), w);
    tw += w;
    d = {6'd63, 6'd62, 6'd61, 6'b100100};
    send(d, expect_out(d), w);
    tw += w;
    d = {6'b001000, 6'd0, 6'd0, 6'd0};
    send(d, expect_out(d), w);
    tw += w;
    check("resume_in_ready_waits", 32'(tw), 32'd0);

    // Illegal write in RUN: dropped, sticky error, cleared by next cfg_done
    do_write(2'd0, 6'd0, 2'b11);
    @(negedge clk);
    check("run_write_err", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    send(24'h0, 8'h00, w);
    pulse_start();
    idle(3);
    @(negedge clk);
    check("err_sticky_in_load", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    check("err_cleared_by_done", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;

    // cfg_start together with a transfer while output is stalled
    out_ready = 1'b0;
    d = {6'd0, 6'd6, 6'd11, 6'b100100};
    in_valid = 1'b1; in_data = d; cfg_start = 1'b1;
    @(negedge clk);
    check("start_xfer_in_ready", 32'(in_ready), 32'd1);
    sb_q.push_back(expect_out(d));
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_busy", 32'(cfg_busy), 32'd1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("after_drain_busy", 32'(cfg_busy), 32'd1);
    @(posedge clk); #1;
`ifdef LOGICNET_LUT_READBACK_EN
    cfg_re = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'b100100;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    @(negedge clk);
    check("readback_n0", 32'(cfg_rdata), 32'd1);
    @(posedge clk); #1;
    cfg_re = 1'b1; cfg_neuron = 2'd3; cfg_addr = 6'b001000;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    @(negedge clk);
    check("readback_n3", 32'(cfg_rdata), 32'd3);
    @(posedge clk); #1;
`endif
    load_entry(2'd2, 6'd5, 2'b10);
    @(negedge clk);
    check("reload_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    pulse_done();
    d = {6'b001000, 6'd5, 6'd0, 6'b100100};
    send(d, 8'b11_10_00_01, w);

    // Reset mid-stream clears in-flight sample and tables
    idle(2);
    out_ready = 1'b0;
    send(d, expect_out(d), w);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(cfg_busy), 32'd1);
    sb_q.delete();
    for (int n = 0; n < 4; n++) for (int a = 0; a < 64; a++) mdl[n][a] = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    pulse_done();
    send(d, 8'h00, w);

    // Drain scoreboard
    tw = 0;
    while (sb_q.size() != 0 && tw < 20) begin
      @(posedge clk);
      tw++;
    end
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
